// File: rtl/dir_pkg.sv
// dir_pkg: direction channel enum, button level constants and sizing helper
// shared by dir_button_conditioner and its per-channel debouncer.
package dir_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN} dir_e;
    localparam int DIR_N = 4;
    localparam logic BTN_RELEASED = 1'b1;
    localparam logic BTN_PRESSED = 1'b0;
    function automatic int max3(int a, int b, int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/dir_button_conditioner_if.sv
// dir_button_conditioner_if: raw active-low buttons in, one-cycle active-low
// direction pulses plus an any_press flag out.
interface dir_button_conditioner_if;
    logic btn_up_n, btn_right_n, btn_left_n, btn_down_n;
    logic up, right, left, down, any_press;
    modport master (
        output btn_up_n, btn_right_n, btn_left_n, btn_down_n,
        input  up, right, left, down, any_press
    );
    modport slave (
        input  btn_up_n, btn_right_n, btn_left_n, btn_down_n,
        output up, right, left, down, any_press
    );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: one button channel - 2-flop sync, stability counter, press pulse.
// DIR_AUTO_REPEAT_EN adds a hold-to-repeat counter producing extra press pulses.
module button_debounce
    import dir_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
`ifdef DIR_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_PERIOD = 10000000,
`endif
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pulse_n
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic s, d, d_q, fire;
    assign s = sync[1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {2{BTN_RELEASED}};
            d <= BTN_RELEASED;
            d_q <= BTN_RELEASED;
            cnt <= '0;
            pulse_n <= BTN_RELEASED;
        end else begin
            sync <= {sync[0], btn_n};
            cnt <= (s != d && cnt != DEB_LAST) ? cnt + 1'b1 : '0;
            if (s != d && cnt == DEB_LAST) d <= s;
            d_q <= d;
            pulse_n <= ((d_q == BTN_RELEASED && d == BTN_PRESSED) || fire) ? BTN_PRESSED : BTN_RELEASED;
        end
    end
`ifdef DIR_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rep;
    logic first;
    // counting starts once the initial press pulse has been issued
    assign fire = d == BTN_PRESSED && d_q == BTN_PRESSED && rep == (first ? DLY_LAST : PER_LAST);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep <= '0;
            first <= 1'b1;
        end else if (d == BTN_RELEASED || d_q == BTN_RELEASED) begin
            rep <= '0;
            first <= 1'b1;
        end else if (fire) begin
            rep <= '0;
            first <= 1'b0;
        end else begin
            rep <= rep + 1'b1;
        end
    end
`else
    assign fire = 1'b0;
`endif
endmodule

// File: rtl/dir_button_conditioner.sv
// dir_button_conditioner: four independent debounced direction channels emitting
// one active-low pulse per press. Optional auto-repeat via DIR_AUTO_REPEAT_EN.
module dir_button_conditioner
    import dir_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input logic clk,
    input logic rst,
    dir_button_conditioner_if.slave bus
);
    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    logic [DIR_N-1:0] btn, pls;
    assign btn[DIR_UP] = bus.btn_up_n;
    assign btn[DIR_RIGHT] = bus.btn_right_n;
    assign btn[DIR_LEFT] = bus.btn_left_n;
    assign btn[DIR_DOWN] = bus.btn_down_n;
    for (genvar g = int'(DIR_UP); g <= int'(DIR_DOWN); g++) begin : g_ch
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef DIR_AUTO_REPEAT_EN
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
            .CNT_W(CNT_W)
        ) u_deb (
            .clk(clk),
            .rst(rst),
            .btn_n(btn[g]),
            .pulse_n(pls[g])
        );
    end
    assign bus.up = pls[DIR_UP];
    assign bus.right = pls[DIR_RIGHT];
    assign bus.left = pls[DIR_LEFT];
    assign bus.down = pls[DIR_DOWN];
    assign bus.any_press = ~&pls;
endmodule

// File: tb/tb_dir_button_conditioner.sv
// tb_dir_button_conditioner: directed stimulus, per-cycle check against a
// window-based behavioural model, plus literal pulse timing/count checks.
module tb_dir_button_conditioner;
    import dir_pkg::*;
    localparam int DEB = 4, RD = 12, RP = 6;
`ifdef DIR_AUTO_REPEAT_EN
    localparam int RIGHT_N = 3, UP_N = 6, UP_LAST = 43;
`else
    localparam int RIGHT_N = 1, UP_N = 1, UP_LAST = 7;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] raw = 4'hf;
    logic [3:0] outs;
    logic any;
    int cyc = 0, tests = 0, fails = 0, ap_last = -1;
    int pcnt [4] = '{0, 0, 0, 0};
    int plast [4] = '{-1, -1, -1, -1};
    int snap [4];
    int c0;

    dir_button_conditioner_if bus();
    dir_button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.btn_up_n = raw[DIR_UP];
    assign bus.btn_right_n = raw[DIR_RIGHT];
    assign bus.btn_left_n = raw[DIR_LEFT];
    assign bus.btn_down_n = raw[DIR_DOWN];
    assign outs = {bus.down, bus.left, bus.right, bus.up};
    assign any = bus.any_press;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // L = consecutive cycles the accepted level has been "pressed"
    function automatic bit rep_hit(int l);
`ifdef DIR_AUTO_REPEAT_EN
        return (l - 1 >= RD) && ((l - 1 - RD) % RP == 0);
`else
        return l < 0;
`endif
    endfunction

    // Model: accepted level flips once the last DEB synced samples all disagree with it
    bit [DEB-1:0] win [4];
    bit dm [4], rawq [4];
    int len [4];
    logic [3:0] exp_o = 4'hf;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                win[i] = '1; dm[i] = 1'b1; rawq[i] = 1'b1; len[i] = 0;
            end
            exp_o = 4'hf;
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_o[i] = !(len[i] == 1 || rep_hit(len[i]));
                if (win[i] == {DEB{~dm[i]}}) dm[i] = ~dm[i];
                len[i] = dm[i] ? 0 : len[i] + 1;
                win[i] = {win[i][DEB-2:0], rawq[i]};
                rawq[i] = raw[i];
            end
        end
    end

    always @(negedge clk) begin
        check("outs_vs_model", {28'd0, outs}, {28'd0, exp_o});
        check("any_vs_model", {31'd0, any}, {31'd0, exp_o != 4'hf});
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!outs[i]) begin
                pcnt[i]++;
                plast[i] = cyc;
            end
        if (any) ap_last = cyc;
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 4; i++) snap[i] = pcnt[i];
    endtask

    initial begin
        #1 rst = 1'b0;
        idle(2);
        check("rst_outs", {28'd0, outs}, 32'hf);
        check("rst_any", {31'd0, any}, 0);
        rst = 1'b1;
        idle(5);
        // clean press on right
        take_snap();
        raw[DIR_RIGHT] = 1'b0;
        idle(6);
        check("right_before", {31'd0, bus.right}, 1);
        idle(1);
        check("right_pulse", {31'd0, bus.right}, 0);
        check("right_any", {31'd0, any}, 1);
        idle(1);
        check("right_after", {31'd0, bus.right}, 1);
        idle(12);
        raw[DIR_RIGHT] = 1'b1;
        idle(15);
        check("right_count", pcnt[DIR_RIGHT] - snap[DIR_RIGHT], RIGHT_N);
        // bounce on down
        take_snap();
        raw[DIR_DOWN] = 1'b0; idle(1);
        raw[DIR_DOWN] = 1'b1; idle(1);
        raw[DIR_DOWN] = 1'b0; idle(1);
        raw[DIR_DOWN] = 1'b1; idle(1);
        check("down_bounce_quiet", pcnt[DIR_DOWN] - snap[DIR_DOWN], 0);
        c0 = cyc;
        raw[DIR_DOWN] = 1'b0;
        idle(10);
        raw[DIR_DOWN] = 1'b1;
        idle(12);
        check("down_count", pcnt[DIR_DOWN] - snap[DIR_DOWN], 1);
        check("down_time", plast[DIR_DOWN] - c0, 7);
        // diagonal up+left
        take_snap();
        c0 = cyc;
        raw[DIR_UP] = 1'b0;
        raw[DIR_LEFT] = 1'b0;
        idle(7);
        check("diag_outs", {28'd0, outs}, 32'b1010);
        check("diag_any", {31'd0, any}, 1);
        idle(2);
        raw[DIR_UP] = 1'b1;
        raw[DIR_LEFT] = 1'b1;
        idle(12);
        check("diag_up_count", pcnt[DIR_UP] - snap[DIR_UP], 1);
        check("diag_left_count", pcnt[DIR_LEFT] - snap[DIR_LEFT], 1);
        check("diag_any_time", ap_last - c0, 7);
        // left held through reset release
        take_snap();
        #2 rst = 1'b0;
        raw[DIR_LEFT] = 1'b0;
        idle(2);
        rst = 1'b1;
        c0 = cyc;
        idle(10);
        raw[DIR_LEFT] = 1'b1;
        idle(12);
        check("held_rst_count", pcnt[DIR_LEFT] - snap[DIR_LEFT], 1);
        check("held_rst_time", plast[DIR_LEFT] - c0, 7);
        // reset asserted mid-pulse
        raw[DIR_RIGHT] = 1'b0;
        idle(7);
        check("midpulse_low", {31'd0, bus.right}, 0);
        #2 rst = 1'b0;
        #1 check("midpulse_rst_right", {31'd0, bus.right}, 1);
        check("midpulse_rst_any", {31'd0, any}, 0);
        raw[DIR_RIGHT] = 1'b1;
        @(negedge clk) rst = 1'b1;
        idle(10);
        // long hold on up (auto-repeat when enabled)
        take_snap();
        c0 = cyc;
        raw[DIR_UP] = 1'b0;
        idle(40);
        raw[DIR_UP] = 1'b1;
        idle(20);
        check("up_hold_count", pcnt[DIR_UP] - snap[DIR_UP], UP_N);
        check("up_hold_last", plast[DIR_UP] - c0, UP_LAST);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dir_button_conditioner.md
Name: dir_button_conditioner

Overview:
- Upstream input stage for the grid-movement logic on the 8x8 board.
- Takes four raw, bouncy, asynchronous active-low push buttons and synchronizes and debounces them.
- Emits a clean single-cycle active-low pulse on each press (up, right, left, down), which the movement stage consumes directly.
- One press yields exactly one move, however long the button is held.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be >= 2.
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 10000000: cycles between later auto-repeat pulses. Used only with the optional feature.
- CNT_W, $clog2(max of the three above)+1: counter width, derived.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- btn_up_n  in  1  raw up button, active-low, asynchronous.
- btn_right_n  in  1  raw right button, active-low, asynchronous.
- btn_left_n  in  1  raw left button, active-low, asynchronous.
- btn_down_n  in  1  raw down button, active-low, asynchronous.
- up  out  1  active-low one-cycle press pulse.
- right  out  1  active-low one-cycle press pulse.
- left  out  1  active-low one-cycle press pulse.
- down  out  1  active-low one-cycle press pulse.
- any_press  out  1  active-high; 1 in any cycle where at least one direction pulse is low.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, debounced state and outputs all go to 1 (released).
  - Counters go to 0; any_press goes to 0.
  - This takes effect immediately, including mid-debounce or mid-pulse.
- Per channel, the four channels are identical and independent.
- Synchronizer: two flops, reset value 1. The synced level s lags the raw input by 2 clock edges.
- Debounce:
  - The debounced level d is held in a register.
  - While s != d, cnt increments each cycle.
  - When s != d and cnt == DEBOUNCE_CYCLES-1: d <= s and cnt <= 0.
  - Any cycle with s == d sets cnt <= 0, so a single bounce restarts the count.
  - Result: d changes exactly DEBOUNCE_CYCLES edges after s first differs, provided s is held.
- Pulse:
  - Output is registered: low for exactly one cycle in the cycle after d goes 1->0; high otherwise.
  - Release (d 0->1) produces no pulse.
- Total latency: raw falling edge to output low = 2 + DEBOUNCE_CYCLES + 1 edges.
- Simultaneous presses: each channel pulses independently, so diagonal moves are possible. No priority, no suppression; resolving them belongs to the movement stage.
- Button held through reset release: d starts at 1, so the held level is treated as a new press and pulses once after the normal latency.
- Glitch shorter than DEBOUNCE_CYCLES: no change to d, no pulse.
- Counters saturate implicitly; no wrap is possible because cnt is cleared at the threshold.

Optional Feature:
- Macro: DIR_AUTO_REPEAT_EN.
- Defined:
  - While d == 0, a per-channel repeat counter runs.
  - The first extra pulse comes REPEAT_DELAY cycles after the initial pulse; further pulses come every REPEAT_PERIOD cycles.
  - Releasing the button (d -> 1) or reset clears the repeat counter immediately.
  - Each extra pulse is one cycle low, same format as the press pulse.
- Undefined: no repeat logic and no repeat registers; REPEAT_* are ignored. Exactly one pulse per press.

Decomposition:
- Package dir_pkg:
  - typedef enum of the four directions (DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN), used to index the channel array.
  - Constants BTN_RELEASED = 1'b1 and BTN_PRESSED = 1'b0.
- Sub-module button_debounce: one channel (synchronizer, debounce counter, pulse, optional repeat). Instantiated four times through a generate loop over the enum.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=12, REPEAT_PERIOD=6):
- Reset: rst=0 with all buttons at 1, release after 2 cycles -> up, right, left and down are 1 and any_press is 0 throughout; rst=0 mid-pulse forces the output to 1 at once.
- Clean press: btn_right_n 1->0 and held 20 cycles -> right is low for exactly 1 cycle, 7 edges after the edge that sampled the 0; no pulse on release.
- Bounce: btn_down_n toggled 0,1,0,1 on alternate cycles, then held 0 -> no pulse during toggling; a single pulse 7 edges after the final stable 0.
- Diagonal: btn_up_n and btn_left_n fall in the same cycle -> up and left are low in the same single cycle and any_press=1 that cycle.
- Held through reset: btn_left_n=0 before rst releases -> exactly one left pulse 7 edges after the reset release.
- DIR_AUTO_REPEAT_EN: btn_up_n held 40 cycles -> up pulses at t0, t0+12, t0+18, t0+24, ...; release stops repetition with no further pulse.
